// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Registered execute-stage ALU with a valid/ready handshake on both
//            sides. It provides ADD/SUB/AND/OR/SLT. An optional iterative
//            MULTU/DIVU unit writes the HI/LO registers, and MFHI/MFLO read
//            them back.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   in_valid  in   request valid
//   in_ready  out  request accepted this cycle
//   alu_op    in   [2:0] operation class from main control
//   funct     in   [5:0] R-type function field
//   op_a      in   [WIDTH-1:0] operand A
//   op_b      in   [WIDTH-1:0] operand B
//   out_valid out  result valid
//   out_ready in   consumer accepts result
//   result    out  [WIDTH-1:0] registered result
//   zero      out  result == 0, registered with result
//   illegal   out  undecodable request, registered with result
//   busy      out  iterative operation in progress
// Configuration
//   ALU_EXEC_MULDIV_EN : when defined, MULTU/DIVU/MFHI/MFLO, HI/LO and the
//                        CALC state are built. When undefined, those codes
//                        decode as illegal.
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
`ifdef ALU_EXEC_MULDIV_EN
    localparam logic [5:0] c_FN_MULTU = 6'b011001;
    localparam logic [5:0] c_FN_DIVU  = 6'b011011;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;
    localparam int         c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    logic             w_accept;
    logic [WIDTH-1:0] w_res;
    logic             w_ill;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_slt;

`ifdef ALU_EXEC_MULDIV_EN
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    // The working pair is {remainder, quotient} for divide and {high, low}
    // of the partial product for multiply. r_opnd holds the divisor or the
    // multiplicand.
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic [c_CW-1:0]  r_count;

    logic             w_muldiv_start;
    logic             w_is_div;
    logic             w_div0;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_iter_hi;
    logic [WIDTH-1:0] w_iter_lo;
`endif

    assign out_valid = (r_state == HOLD);
    assign in_ready  = (r_state == IDLE) && (!out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;
`ifdef ALU_EXEC_MULDIV_EN
    assign busy      = (r_state == CALC);
`else
    assign busy      = 1'b0;
`endif

    assign w_sum  = op_a + op_b;
    assign w_diff = op_a - op_b;
    assign w_slt  = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};

    // Request decode
    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
        w_muldiv_start = 1'b0;
        w_is_div       = 1'b0;
        w_div0         = 1'b0;
`endif
        case (alu_op)
            3'b000: w_res = w_sum;
            3'b001: w_res = w_slt;
            3'b010: w_res = op_a & op_b;
            3'b011: w_res = op_a | op_b;
            3'b101: w_res = w_diff;
            3'b100: begin
                case (funct)
                    c_FN_ADD: w_res = w_sum;
                    c_FN_SUB: w_res = w_diff;
                    c_FN_AND: w_res = op_a & op_b;
                    c_FN_OR:  w_res = op_a | op_b;
                    c_FN_SLT: w_res = w_slt;
`ifdef ALU_EXEC_MULDIV_EN
                    c_FN_MULTU: w_muldiv_start = 1'b1;
                    c_FN_DIVU: begin
                        // A zero divisor completes at once with the
                        // conventional all-ones quotient.
                        if (op_b == '0) begin
                            w_div0 = 1'b1;
                            w_res  = '1;
                        end else begin
                            w_muldiv_start = 1'b1;
                            w_is_div       = 1'b1;
                        end
                    end
                    c_FN_MFHI: w_res = r_hi;
                    c_FN_MFLO: w_res = r_lo;
`endif
                    default: w_ill = 1'b1;
                endcase
            end
            default: w_ill = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_MULDIV_EN
    // One iteration of unsigned shift-add multiply and of restoring divide
    always_comb begin
        w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift   = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_trial   = w_shift - {1'b0, r_opnd};
        if (r_is_div) begin
            if (!w_trial[WIDTH]) begin
                w_iter_hi = w_trial[WIDTH-1:0];
                w_iter_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_iter_hi = w_shift[WIDTH-1:0];
                w_iter_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_iter_hi = w_mul_sum[WIDTH:1];
            w_iter_lo = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef ALU_EXEC_MULDIV_EN
                    w_state_next = w_muldiv_start ? CALC : HOLD;
`else
                    w_state_next = HOLD;
`endif
                end
            end
`ifdef ALU_EXEC_MULDIV_EN
            CALC: begin
                if (r_count == c_LAST) begin
                    w_state_next = HOLD;
                end
            end
`endif
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: result registers, HI/LO and the iterative working registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
            r_hi      <= '0;
            r_lo      <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_count   <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_result  <= w_res;
                r_zero    <= (w_res == '0);
                r_illegal <= w_ill;
`ifdef ALU_EXEC_MULDIV_EN
                if (w_div0) begin
                    r_hi <= op_a;
                    r_lo <= '1;
                end
                r_count  <= '0;
                r_is_div <= w_is_div;
                r_acc_hi <= '0;
                r_acc_lo <= w_is_div ? op_a : op_b;
                r_opnd   <= w_is_div ? op_b : op_a;
`endif
            end
`ifdef ALU_EXEC_MULDIV_EN
            else if (r_state == CALC) begin
                r_acc_hi <= w_iter_hi;
                r_acc_lo <= w_iter_lo;
                r_count  <= r_count + 1'b1;
                if (r_count == c_LAST) begin
                    r_hi     <= w_iter_hi;
                    r_lo     <= w_iter_lo;
                    r_result <= w_iter_lo;
                    r_zero   <= (w_iter_lo == '0);
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Self-checking bench for alu_exec_unit (WIDTH=32). Randomized and
//            directed requests are compared against a behavioural model that
//            keeps its own HI/LO state.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;
    logic         busy;

    int total;
    int bad;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: expected result, illegal flag, latency, busy cycles.
    function automatic void ref_op(input logic [2:0] op, input logic [5:0] fn,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic il,
                                   output int lat, output int bz);
        logic [63:0] p;
        r = '0; il = 1'b0; lat = 1; bz = 0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd5: r = a - b;
            3'd4: begin
                case (fn)
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_EXEC_MULDIV_EN
                    6'h19: begin
                        p = {32'd0, a} * {32'd0, b};
                        m_hi = p[63:32]; m_lo = p[31:0];
                        r = m_lo; lat = W + 1; bz = W;
                    end
                    6'h1b: begin
                        if (b == 0) begin
                            m_hi = a; m_lo = 32'hFFFF_FFFF;
                        end else begin
                            m_hi = a % b; m_lo = a / b;
                            lat = W + 1; bz = W;
                        end
                        r = m_lo;
                    end
                    6'h10: r = m_hi;
                    6'h12: r = m_lo;
`endif
                    default: il = 1'b1;
                endcase
            end
            default: il = 1'b1;
        endcase
    endfunction

    // Drives one request, scrambles operands after acceptance, measures
    // latency and busy cycles, holds out_ready low for 'stall' cycles, then
    // releases it. Must be entered on a falling edge with the unit idle.
    task automatic send(input logic [2:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                        output logic [W-1:0] res, output logic z, output logic il,
                        output int lat, output int bc, output bit stable,
                        output bit rdy_low, output bit done);
        int t;
        res = '0; z = 1'b0; il = 1'b0; lat = -1; bc = 0;
        stable = 1'b1; rdy_low = 1'b1; done = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; alu_op = op; funct = fn; op_a = a; op_b = b;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        op_a = $urandom; op_b = $urandom;
        alu_op = 3'($urandom); funct = 6'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            bc += int'(busy);
            @(negedge clk);
            lat++;
        end
        res = result; z = zero; il = illegal;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (result !== res || zero !== z || illegal !== il || out_valid !== 1'b1)
                stable = 1'b0;
            if (in_ready !== 1'b0)
                rdy_low = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        done = (out_valid === 1'b0) && (in_ready === 1'b1);
        out_ready = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_reset();
        do_reset(2);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got %h exp 0", result); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        total++; if (zero !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL reset_flags got zero=%b illegal=%b exp 0 0", zero, illegal); end
    endtask

    task automatic test_alu_directed();
        logic [W-1:0] r; logic z, il; int lat, bc; bit st, rl, dn;
        send(3'b100, 6'h20, 32'd5, 32'd7, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'd12 || z !== 1'b0) begin bad++; $display("FAIL add_5_7 got %h z=%b exp 0000000c z=0", r, z); end
        total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got %0d exp 1", lat); end
        send(3'b001, 6'h00, 32'hFFFF_FFFF, 32'd1, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL slt_signed got %h exp 1", r); end
        send(3'b101, 6'h00, 32'h1234, 32'h1234, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'd0 || z !== 1'b1) begin bad++; $display("FAIL sub_equal got %h z=%b exp 0 z=1", r, z); end
        send(3'b000, 6'h00, 32'hFFFF_FFFF, 32'd2, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL add_wrap got %h exp 1", r); end
    endtask

    task automatic test_illegal();
        logic [W-1:0] r; logic z, il; int lat, bc; bit st, rl, dn;
        send(3'b110, 6'h20, 32'd9, 32'd3, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (il !== 1'b1 || r !== 32'd0) begin bad++; $display("FAIL illegal_aluop got il=%b r=%h exp 1 0", il, r); end
        send(3'b100, 6'h3f, 32'd9, 32'd3, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (il !== 1'b1 || r !== 32'd0 || lat !== 1) begin bad++; $display("FAIL illegal_funct got il=%b r=%h lat=%0d exp 1 0 1", il, r, lat); end
        send(3'b100, 6'h20, 32'd9, 32'd3, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (il !== 1'b0 || r !== 32'd12) begin bad++; $display("FAIL illegal_clears got il=%b r=%h exp 0 c", il, r); end
    endtask

`ifdef ALU_EXEC_MULDIV_EN
    task automatic test_muldiv();
        logic [W-1:0] r, er; logic z, il, eil; int lat, bc, elat, ebz; bit st, rl, dn;
        ref_op(3'b100, 6'h19, 32'h0001_0000, 32'h0001_0000, er, eil, elat, ebz);
        send(3'b100, 6'h19, 32'h0001_0000, 32'h0001_0000, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'd0 || z !== 1'b1) begin bad++; $display("FAIL multu_result got %h z=%b exp 0 z=1", r, z); end
        total++; if (lat !== 33 || bc !== 32) begin bad++; $display("FAIL multu_timing got lat=%0d busy=%0d exp 33 32", lat, bc); end
        ref_op(3'b100, 6'h10, 32'd0, 32'd0, er, eil, elat, ebz);
        send(3'b100, 6'h10, 32'd0, 32'd0, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'd1 || lat !== 1) begin bad++; $display("FAIL mfhi_after_mul got %h lat=%0d exp 1 1", r, lat); end
        ref_op(3'b100, 6'h1b, 32'd100, 32'd7, er, eil, elat, ebz);
        send(3'b100, 6'h1b, 32'd100, 32'd7, 3, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'd14 || lat !== 33) begin bad++; $display("FAIL divu_100_7 got %h lat=%0d exp e 33", r, lat); end
        total++; if (!st || !rl || !dn) begin bad++; $display("FAIL divu_backpressure got stable=%0d ready_low=%0d release=%0d exp 1 1 1", st, rl, dn); end
        ref_op(3'b100, 6'h10, 32'd0, 32'd0, er, eil, elat, ebz);
        send(3'b100, 6'h10, 32'd0, 32'd0, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL mfhi_rem got %h exp 2", r); end
        ref_op(3'b100, 6'h1b, 32'h55, 32'd0, er, eil, elat, ebz);
        send(3'b100, 6'h1b, 32'h55, 32'd0, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'hFFFF_FFFF || lat !== 1 || bc !== 0) begin bad++; $display("FAIL divu_by_zero got %h lat=%0d busy=%0d exp ffffffff 1 0", r, lat, bc); end
        ref_op(3'b100, 6'h10, 32'd0, 32'd0, er, eil, elat, ebz);
        send(3'b100, 6'h10, 32'd0, 32'd0, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== 32'h55) begin bad++; $display("FAIL mfhi_div0 got %h exp 55", r); end
    endtask
`else
    task automatic test_muldiv();
        logic [W-1:0] r; logic z, il; int lat, bc; bit st, rl, dn;
        logic [5:0] fns [4] = '{6'h19, 6'h1b, 6'h10, 6'h12};
        for (int i = 0; i < 4; i++) begin
            send(3'b100, fns[i], 32'd100, 32'd7, 0, r, z, il, lat, bc, st, rl, dn);
            total++;
            if (il !== 1'b1 || r !== 32'd0 || lat !== 1 || bc !== 0) begin
                bad++;
                $display("FAIL nomuldiv_funct_%h got il=%b r=%h lat=%0d busy=%0d exp 1 0 1 0", fns[i], il, r, lat, bc);
            end
        end
    endtask
`endif

    task automatic test_reset_abort();
        logic [W-1:0] r, er; logic z, il, eil; int lat, bc, elat, ebz; bit st, rl, dn;
        int seen;
        // Abort while holding a result.
        in_valid = 1'b1; alu_op = 3'b000; op_a = 32'd3; op_b = 32'd4; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        do_reset(1);
        total++; if (out_valid !== 1'b0 || result !== 32'd0) begin bad++; $display("FAIL abort_hold got ov=%b r=%h exp 0 0", out_valid, result); end
`ifdef ALU_EXEC_MULDIV_EN
        // Abort mid-iteration: no result appears and HI/LO read back as zero.
        ref_op(3'b100, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, er, eil, elat, ebz);
        send(3'b100, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, z, il, lat, bc, st, rl, dn);
        in_valid = 1'b1; alu_op = 3'b100; funct = 6'h1b; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL calc_busy got busy=%b ready=%b exp 1 0", busy, in_ready); end
        do_reset(1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
            @(negedge clk);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_calc got %0d active cycles exp 0", seen); end
        ref_op(3'b100, 6'h12, 32'd0, 32'd0, er, eil, elat, ebz);
        send(3'b100, 6'h12, 32'd0, 32'd0, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== er) begin bad++; $display("FAIL abort_lo got %h exp %h", r, er); end
        ref_op(3'b100, 6'h10, 32'd0, 32'd0, er, eil, elat, ebz);
        send(3'b100, 6'h10, 32'd0, 32'd0, 0, r, z, il, lat, bc, st, rl, dn);
        total++; if (r !== er) begin bad++; $display("FAIL abort_hi got %h exp %h", r, er); end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] r, er, a, b; logic z, il, eil; int lat, bc, elat, ebz; bit st, rl, dn;
        logic [2:0] op; logic [5:0] fn; int stall;
        logic [5:0] legal [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h19, 6'h1b, 6'h10, 6'h12};
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'($urandom);
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal[$urandom_range(0, 8)];
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 1000));
                2: b = a;
                default: b = $urandom;
            endcase
            stall = $urandom_range(0, 2);
            ref_op(op, fn, a, b, er, eil, elat, ebz);
            send(op, fn, a, b, stall, r, z, il, lat, bc, st, rl, dn);
            total++;
            if (r !== er || il !== eil || z !== (er == 0)) begin
                bad++;
                $display("FAIL rand_%0d op=%0d fn=%h a=%h b=%h got r=%h il=%b z=%b exp r=%h il=%b",
                         i, op, fn, a, b, r, il, z, er, eil);
            end
            total++;
            if (lat !== elat || bc !== ebz) begin
                bad++;
                $display("FAIL rand_timing_%0d got lat=%0d busy=%0d exp %0d %0d", i, lat, bc, elat, ebz);
            end
            total++;
            if (!st || !rl || !dn) begin
                bad++;
                $display("FAIL rand_handshake_%0d got stable=%0d ready_low=%0d release=%0d exp 1 1 1", i, st, rl, dn);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r, a, b; logic z, il; int lat, bc; bit st, rl, dn;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            send(3'b011, 6'h00, a, b, 0, r, z, il, lat, bc, st, rl, dn);
            total++;
            if (r !== (a | b) || lat !== 1 || !dn) begin
                bad++;
                $display("FAIL b2b_or_%0d got r=%h lat=%0d release=%0d exp %h 1 1", i, r, lat, dn, a | b);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; funct = '0; op_a = '0; op_b = '0;
        total = 0; bad = 0; m_hi = '0; m_lo = '0;
        test_reset();
        test_alu_directed();
        test_illegal();
        test_muldiv();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
